// File: rtl/alu_arbiter_if.sv
// Bundle between alu_arbiter, its two requesters and the shared ALU.
// slave is the arbiter side; master is the clients/ALU side.
interface alu_arbiter_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       req;
   logic [2:0]       sel0;
   logic [2:0]       sel1;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic [1:0]       gnt;
   logic [1:0]       done;
   logic [WIDTH-1:0] result;
   logic [3:0]       nzvc;
   logic             err;
   logic [WIDTH-1:0] alu_in1;
   logic [WIDTH-1:0] alu_in2;
   logic [2:0]       alu_sel;
   logic [WIDTH-1:0] alu_result;
   logic [3:0]       alu_nzvc;

   modport slave (
      input  req, sel0, sel1, a0, b0, a1, b1,
      input  alu_result, alu_nzvc,
      output gnt, done, result, nzvc, err,
      output alu_in1, alu_in2, alu_sel
   );

   modport master (
      output req, sel0, sel1, a0, b0, a1, b1,
      output alu_result, alu_nzvc,
      input  gnt, done, result, nzvc, err,
      input  alu_in1, alu_in2, alu_sel
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8-bit NZVC ALU
// between two requesters: IDLE -> EXEC -> DONE.
module alu_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic         clock,
   input  logic         reset,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic             id_q, id_d;
   logic [2:0]       sel_q, sel_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [1:0]       done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       nzvc_q, nzvc_d;
   logic             err_q, err_d;
   logic             win;

   // With both pending, the one that did not win last time goes.
   always_comb begin
      win = 1'b0;
      unique case (1'b1)
         (bus.req == 2'b11): win = ~last_q;
         (bus.req == 2'b10): win = 1'b1;
         default:            win = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      id_d     = id_q;
      sel_d    = sel_q;
      a_d      = a_q;
      b_d      = b_q;
      gnt_d    = 2'b00;
      done_d   = 2'b00;
      result_d = result_q;
      nzvc_d   = nzvc_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               id_d    = win;
               sel_d   = win ? bus.sel1 : bus.sel0;
               a_d     = win ? bus.a1 : bus.a0;
               b_d     = win ? bus.b1 : bus.b0;
               gnt_d   = win ? 2'b10 : 2'b01;
               state_d = EXEC;
            end
         end
         EXEC: begin
            // ALU outputs are undefined for unsupported selects.
            if (sel_q == 3'b000) begin
               result_d = bus.alu_result;
               nzvc_d   = bus.alu_nzvc;
               err_d    = 1'b0;
            end else begin
               result_d = '0;
               nzvc_d   = 4'b0000;
               err_d    = 1'b1;
            end
            done_d  = id_q ? 2'b10 : 2'b01;
            last_d  = id_q;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         id_q     <= 1'b0;
         sel_q    <= 3'b000;
         a_q      <= '0;
         b_q      <= '0;
         gnt_q    <= 2'b00;
         done_q   <= 2'b00;
         result_q <= '0;
         nzvc_q   <= 4'b0000;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         id_q     <= id_d;
         sel_q    <= sel_d;
         a_q      <= a_d;
         b_q      <= b_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         result_q <= result_d;
         nzvc_q   <= nzvc_d;
         err_q    <= err_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.done    = done_q;
   assign bus.result  = result_q;
   assign bus.nzvc    = nzvc_q;
   assign bus.err     = err_q;
   assign bus.alu_in1 = a_q;
   assign bus.alu_in2 = b_q;
   assign bus.alu_sel = sel_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 8-bit add ALU.
// Each task drives one scenario and checks hand-computed values.
module tb_alu_arbiter;
   logic clock;
   logic reset;
   int   checks;
   int   errors;

   alu_arbiter_if #(.WIDTH(8)) bus ();

   alu_arbiter #(.WIDTH(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ALU: select 000 is add; anything else gives junk the arbiter must drop.
   always_comb begin
      logic [8:0] s;
      s = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
      if (bus.alu_sel == 3'b000) begin
         bus.alu_result = s[7:0];
         bus.alu_nzvc = {s[7], s[7:0] == 8'h00,
                         (bus.alu_in1[7] == bus.alu_in2[7]) &&
                         (s[7] != bus.alu_in1[7]), s[8]};
      end else begin
         bus.alu_result = 8'hA5;
         bus.alu_nzvc   = 4'b1111;
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.req = 2'b00;
      bus.sel0 = 3'b000; bus.sel1 = 3'b000;
      bus.a0 = 8'h00; bus.b0 = 8'h00;
      bus.a1 = 8'h00; bus.b1 = 8'h00;
      tick(); tick();
      reset = 1'b0;
      checks++;
      if (bus.gnt !== 2'b00 || bus.done !== 2'b00 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL rst_ctl got gnt=%b done=%b err=%b want 00 00 0",
                  bus.gnt, bus.done, bus.err);
      end
      checks++;
      if (bus.result !== 8'h00 || bus.nzvc !== 4'b0000) begin
         errors++;
         $display("FAIL rst_res got %h/%b want 00/0000", bus.result, bus.nzvc);
      end
      checks++;
      if (bus.alu_in1 !== 8'h00 || bus.alu_in2 !== 8'h00 ||
          bus.alu_sel !== 3'b000) begin
         errors++;
         $display("FAIL rst_alu got %h %h %b want 00 00 000",
                  bus.alu_in1, bus.alu_in2, bus.alu_sel);
      end
      tick();
      checks++;
      if (bus.gnt !== 2'b00) begin
         errors++;
         $display("FAIL idle_gnt got %b want 00", bus.gnt);
      end
   endtask

   task automatic test_req0;
      bus.req = 2'b01; bus.sel0 = 3'b000; bus.a0 = 8'h7F; bus.b0 = 8'h01;
      tick();
      bus.req = 2'b00;
      checks++;
      if (bus.gnt !== 2'b01 || bus.done !== 2'b00) begin
         errors++;
         $display("FAIL r0_gnt got gnt=%b done=%b want 01 00", bus.gnt, bus.done);
      end
      checks++;
      if (bus.alu_in1 !== 8'h7F || bus.alu_in2 !== 8'h01 ||
          bus.alu_sel !== 3'b000) begin
         errors++;
         $display("FAIL r0_alu got %h %h %b want 7f 01 000",
                  bus.alu_in1, bus.alu_in2, bus.alu_sel);
      end
      tick();
      checks++;
      if (bus.done !== 2'b01 || bus.gnt !== 2'b00) begin
         errors++;
         $display("FAIL r0_done got done=%b gnt=%b want 01 00", bus.done, bus.gnt);
      end
      checks++;
      if (bus.result !== 8'h80 || bus.nzvc !== 4'b1010 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL r0_res got %h/%b/%b want 80/1010/0",
                  bus.result, bus.nzvc, bus.err);
      end
      tick();
      checks++;
      if (bus.done !== 2'b00 || bus.result !== 8'h80 ||
          bus.alu_in1 !== 8'h7F) begin
         errors++;
         $display("FAIL r0_hold got done=%b res=%h in1=%h want 00 80 7f",
                  bus.done, bus.result, bus.alu_in1);
      end
   endtask

   task automatic test_req1;
      bus.req = 2'b10; bus.sel1 = 3'b000; bus.a1 = 8'hFF; bus.b1 = 8'h01;
      tick();
      bus.req = 2'b00;
      checks++;
      if (bus.gnt !== 2'b10) begin
         errors++;
         $display("FAIL r1_gnt got %b want 10", bus.gnt);
      end
      tick();
      checks++;
      if (bus.done !== 2'b10 || bus.result !== 8'h00 || bus.nzvc !== 4'b0101) begin
         errors++;
         $display("FAIL r1_res got done=%b %h/%b want 10 00/0101",
                  bus.done, bus.result, bus.nzvc);
      end
      tick();
   endtask

   task automatic test_back_to_back;
      logic [1:0] eg;
      logic [7:0] er;
      logic [3:0] ef;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.req = 2'b11;
      bus.sel0 = 3'b000; bus.a0 = 8'h10; bus.b0 = 8'h20;
      bus.sel1 = 3'b000; bus.a1 = 8'h80; bus.b1 = 8'h80;
      for (int k = 0; k < 4; k++) begin
         eg = (k % 2 == 0) ? 2'b01 : 2'b10;
         er = (k % 2 == 0) ? 8'h30 : 8'h00;
         ef = (k % 2 == 0) ? 4'b0000 : 4'b0111;
         tick();
         checks++;
         if (bus.gnt !== eg || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL rr_gnt%0d got gnt=%b done=%b want %b 00",
                     k, bus.gnt, bus.done, eg);
         end
         tick();
         checks++;
         if (bus.done !== eg || bus.gnt !== 2'b00 ||
             bus.result !== er || bus.nzvc !== ef) begin
            errors++;
            $display("FAIL rr_done%0d got %b %b %h/%b want %b 00 %h/%b",
                     k, bus.done, bus.gnt, bus.result, bus.nzvc, eg, er, ef);
         end
         tick();
         checks++;
         if (bus.gnt !== 2'b00 || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL rr_idle%0d got gnt=%b done=%b want 00 00",
                     k, bus.gnt, bus.done);
         end
      end
      bus.req = 2'b00;
      tick(); tick(); tick();
   endtask

   task automatic test_bad_sel;
      bus.req = 2'b01; bus.sel0 = 3'b011; bus.a0 = 8'h12; bus.b0 = 8'h34;
      tick();
      bus.req = 2'b00;
      checks++;
      if (bus.gnt !== 2'b01 || bus.alu_sel !== 3'b011) begin
         errors++;
         $display("FAIL bad_gnt got %b sel=%b want 01 011", bus.gnt, bus.alu_sel);
      end
      tick();
      checks++;
      if (bus.done !== 2'b01 || bus.err !== 1'b1 ||
          bus.result !== 8'h00 || bus.nzvc !== 4'b0000) begin
         errors++;
         $display("FAIL bad_res got %b err=%b %h/%b want 01 1 00/0000",
                  bus.done, bus.err, bus.result, bus.nzvc);
      end
      tick();
      bus.req = 2'b01; bus.sel0 = 3'b000; bus.a0 = 8'h01; bus.b0 = 8'h01;
      tick();
      bus.req = 2'b00;
      tick();
      checks++;
      if (bus.done !== 2'b01 || bus.err !== 1'b0 ||
          bus.result !== 8'h02 || bus.nzvc !== 4'b0000) begin
         errors++;
         $display("FAIL bad_clr got %b err=%b %h/%b want 01 0 02/0000",
                  bus.done, bus.err, bus.result, bus.nzvc);
      end
      tick();
   endtask

   task automatic test_reset_mid;
      bus.req = 2'b01; bus.sel0 = 3'b000; bus.a0 = 8'h03; bus.b0 = 8'h04;
      tick();
      checks++;
      if (bus.gnt !== 2'b01) begin
         errors++;
         $display("FAIL mid_gnt got %b want 01", bus.gnt);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (bus.gnt !== 2'b00 || bus.done !== 2'b00 || bus.result !== 8'h00 ||
          bus.nzvc !== 4'b0000 || bus.alu_in1 !== 8'h00 ||
          bus.alu_in2 !== 8'h00) begin
         errors++;
         $display("FAIL mid_rst got %b %b %h %b %h %h want all zero",
                  bus.gnt, bus.done, bus.result, bus.nzvc,
                  bus.alu_in1, bus.alu_in2);
      end
      bus.req = 2'b11;
      bus.sel1 = 3'b000; bus.a1 = 8'h40; bus.b1 = 8'h40;
      tick();
      checks++;
      if (bus.done !== 2'b00 || bus.gnt !== 2'b01) begin
         errors++;
         $display("FAIL mid_next got gnt=%b done=%b want 01 00",
                  bus.gnt, bus.done);
      end
   endtask

   task automatic test_drop;
      bus.req = 2'b10;
      tick();
      checks++;
      if (bus.done !== 2'b01 || bus.result !== 8'h07) begin
         errors++;
         $display("FAIL drop_d0 got %b %h want 01 07", bus.done, bus.result);
      end
      tick();
      checks++;
      if (bus.gnt !== 2'b00) begin
         errors++;
         $display("FAIL drop_idle got %b want 00", bus.gnt);
      end
      tick();
      bus.req = 2'b00;
      checks++;
      if (bus.gnt !== 2'b10) begin
         errors++;
         $display("FAIL drop_g1 got %b want 10", bus.gnt);
      end
      tick();
      checks++;
      if (bus.done !== 2'b10 || bus.result !== 8'h80 || bus.nzvc !== 4'b1010) begin
         errors++;
         $display("FAIL drop_d1 got %b %h/%b want 10 80/1010",
                  bus.done, bus.result, bus.nzvc);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (bus.gnt !== 2'b00 || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL drop_quiet%0d got gnt=%b done=%b want 00 00",
                     k, bus.gnt, bus.done);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_req0();
      test_req1();
      test_back_to_back();
      test_bad_sel();
      test_reset_mid();
      test_drop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
